// File: rtl/operand_entry.sv
// Debounced five-button signed decimal operand entry with cursor and saturating digit steps.
// Optional hold-to-repeat on U/D is enabled by defining AUTOREPEAT_EN.
module operand_entry #(
    parameter int NUM_OPERANDS = 2,
    parameter int NUM_DIGITS   = 4,
    parameter int WIDTH        = 16,
    parameter int DEB_CYCLES   = 1000000
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    en,
    input  logic                                                    bt_C,
    input  logic                                                    bt_U,
    input  logic                                                    bt_D,
    input  logic                                                    bt_L,
    input  logic                                                    bt_R,
    input  logic                                                    clear,
    output logic [NUM_OPERANDS*WIDTH-1:0]                           operands,
    output logic [(NUM_OPERANDS > 1 ? $clog2(NUM_OPERANDS) : 1)-1:0] sel,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0]     cursor,
    output logic                                                    done
);
    localparam int SW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;

    function automatic longint pow10(input int unsigned n);
        longint r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint MAXV = pow10(NUM_DIGITS) - 1;
    localparam logic signed [WIDTH:0] MAX_X = (WIDTH+1)'(MAXV);
    localparam logic signed [WIDTH:0] MIN_X = -MAX_X;

    if (MAXV > (longint'(1) << (WIDTH - 1)) - 1) begin : g_width_check
        $error("operand_entry: WIDTH cannot hold +/-(10^NUM_DIGITS - 1)");
    end

`ifdef AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, EDIT, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, EDIT} state_t;
`endif

    state_t                  state_q, state_d;
    logic [4:0]              raw, sync1_q, sync2_q, stable_q, stable_prev_q, press;
    logic [TW-1:0]           tick_cnt_q;
    logic                    tick;
    logic [SW-1:0]           sel_q, sel_d;
    logic [CW-1:0]           cursor_q, cursor_d;
    logic                    done_q, done_d;
    logic signed [WIDTH-1:0] opnd_q [NUM_OPERANDS];
    logic signed [WIDTH-1:0] opnd_d [NUM_OPERANDS];
    logic signed [WIDTH-1:0] cur_v;
    logic signed [WIDTH:0]   step_x, sum_x, dif_x, up_x, dn_x;
    logic                    other_evt, ud_press, rep_up, rep_dn;

    assign raw       = {bt_R, bt_L, bt_D, bt_U, bt_C};
    assign tick      = (tick_cnt_q == TW'(DEB_CYCLES - 1));
    assign press     = stable_q & ~stable_prev_q;
    assign other_evt = clear | press[BC] | press[BL] | press[BR];
    assign ud_press  = press[BU] | press[BD];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            tick_cnt_q    <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            tick_cnt_q    <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) stable_q <= sync2_q;
        end
    end

    // Step ROM: 10^cursor, sign-extended one bit wider so saturation sees the overflow.
    always_comb begin
        step_x = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (cursor_q == CW'(i)) step_x = (WIDTH+1)'(pow10(i));
        cur_v = opnd_q[sel_q];
        sum_x = {cur_v[WIDTH-1], cur_v} + step_x;
        dif_x = {cur_v[WIDTH-1], cur_v} - step_x;
        up_x  = (sum_x > MAX_X) ? MAX_X : sum_x;
        dn_x  = (dif_x < MIN_X) ? MIN_X : dif_x;
    end

`ifdef AUTOREPEAT_EN
    logic [5:0] hold_cnt_q, hold_cnt_d;
    logic       hold_up_q, hold_up_d, held_stable, rep_fire;

    // First repeat after 50 ticks of hold, then every 10 ticks (counter reloads to 40).
    always_comb begin
        held_stable = hold_up_q ? stable_q[BU] : stable_q[BD];
        rep_fire    = (state_q == HOLD) && tick && (hold_cnt_q == 6'd49) && held_stable
                      && !other_evt && !ud_press;
        rep_up      = rep_fire & hold_up_q;
        rep_dn      = rep_fire & ~hold_up_q;
        hold_cnt_d  = hold_cnt_q;
        hold_up_d   = hold_up_q;
        if (state_q == EDIT && ud_press && !other_evt) begin
            hold_cnt_d = '0;
            hold_up_d  = press[BU];
        end else if (state_q == HOLD && tick) begin
            hold_cnt_d = (hold_cnt_q == 6'd49) ? 6'd40 : hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
            hold_up_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_up_q  <= hold_up_d;
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cursor_d = cursor_q;
        done_d   = 1'b0;
        opnd_d   = opnd_q;
        if (state_q != IDLE) begin
            if (clear) begin
                opnd_d[sel_q] = '0;
            end else if (press[BC]) begin
                cursor_d = '0;
                if (sel_q == SW'(NUM_OPERANDS - 1)) begin
                    sel_d  = '0;
                    done_d = 1'b1;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end else if (press[BL]) begin
                cursor_d = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + 1'b1;
            end else if (press[BR]) begin
                cursor_d = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - 1'b1;
            end else if (press[BU] || rep_up) begin
                opnd_d[sel_q] = up_x[WIDTH-1:0];
            end else if (press[BD] || rep_dn) begin
                opnd_d[sel_q] = dn_x[WIDTH-1:0];
            end
        end
        case (state_q)
            IDLE: if (en) state_d = EDIT;
            EDIT: begin
                if (!en) state_d = IDLE;
`ifdef AUTOREPEAT_EN
                else if (ud_press && !other_evt) state_d = HOLD;
`endif
            end
`ifdef AUTOREPEAT_EN
            HOLD: begin
                if (!en) state_d = IDLE;
                else if (other_evt || ud_press || !held_stable) state_d = EDIT;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cursor_q <= '0;
            done_q   <= 1'b0;
            opnd_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cursor_q <= cursor_d;
            done_q   <= done_d;
            opnd_q   <= opnd_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_OPERANDS; i++)
            operands[i*WIDTH +: WIDTH] = opnd_q[i];
    end

    assign sel    = sel_q;
    assign cursor = cursor_q;
    assign done   = done_q;
endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: stimulus queues expected state, a monitor checks on every output change.
module tb_operand_entry;
    localparam int W = 16;
    localparam logic [4:0] B_C = 5'b00001, B_U = 5'b00010, B_D = 5'b00100,
                           B_L = 5'b01000, B_R = 5'b10000;

    logic         clk = 1'b0, reset = 1'b1, en = 1'b0, clear = 1'b0;
    logic [4:0]   btn = '0;
    logic [2*W-1:0] operands;
    logic         sel;
    logic [1:0]   cursor;
    logic         done;

    operand_entry #(
        .NUM_OPERANDS(2),
        .NUM_DIGITS  (4),
        .WIDTH       (16),
        .DEB_CYCLES  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .bt_C    (btn[0]),
        .bt_U    (btn[1]),
        .bt_D    (btn[2]),
        .bt_L    (btn[3]),
        .bt_R    (btn[4]),
        .clear   (clear),
        .operands(operands),
        .sel     (sel),
        .cursor  (cursor),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          nm;
        logic [2*W-1:0] ops;
        logic           sel;
        logic [1:0]     cur;
        logic           done;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   probe_req = 0, probe_ack = 0;
    bit   end_req = 1'b0, end_ack = 1'b0;
    int   cyc = 0;
    int   e_o0 = 0, e_o1 = 0, e_sel = 0, e_cur = 0;
    bit   e_done = 1'b0;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    initial begin : monitor
        logic [2*W+2:0] prev, now;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            now = {operands, sel, cursor};
            if (end_req && !end_ack) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: pending=%0d required=0", q.size());
                end
                end_ack = 1'b1;
            end else if (!reset && (probe_req != probe_ack || now != prev || done)) begin
                probe_ack = probe_req;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: ops=%h sel=%0d cursor=%0d done=%0b, required no change",
                             operands, sel, cursor, done);
                end else begin
                    e = q.pop_front();
                    if (operands !== e.ops || sel !== e.sel || cursor !== e.cur || done !== e.done) begin
                        errors++;
                        $display("FAIL %s: got ops=%h sel=%0d cursor=%0d done=%0b, required ops=%h sel=%0d cursor=%0d done=%0b",
                                 e.nm, operands, sel, cursor, done, e.ops, e.sel, e.cur, e.done);
                    end
                end
            end
            prev = now;
        end
    end

    task automatic push(input string nm);
        exp_t e;
        e.nm   = nm;
        e.ops  = {16'(e_o1), 16'(e_o0)};
        e.sel  = e_sel[0];
        e.cur  = e_cur[1:0];
        e.done = e_done;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        cycles(1);
        btn = m;
        cycles(12);
        btn = '0;
        cycles(12);
    endtask

    task automatic act(input string nm, input logic [4:0] m);
        push(nm);
        press(m);
    endtask

    task automatic probe(input string nm);
        push(nm);
        probe_req++;
        cycles(3);
    endtask

    task automatic quiet(input string nm, input logic [4:0] m);
        press(m);
        probe(nm);
    endtask

    task automatic do_clear(input string nm);
        push(nm);
        cycles(1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(4);
    endtask

    initial begin : stimulus
        cycles(4);
        reset = 1'b0;
        probe("reset state");
        en = 1'b1;
        cycles(3);

        e_o0 = 1;    act("U ones", B_U);
        e_cur = 1;   act("L to 1", B_L);
        e_cur = 2;   act("L to 2", B_L);
        for (int k = 1; k <= 3; k++) begin
            e_o0 = 1 + 100 * k; act("U hundreds", B_U);
        end

        e_o0 = 0;    do_clear("clear op0");
        e_cur = 3;   act("L to 3", B_L);
        for (int k = 1; k <= 9; k++) begin
            e_o0 = 1000 * k; act("U thousands", B_U);
        end
        e_cur = 2;   act("R to 2", B_R);
        for (int k = 1; k <= 9; k++) begin
            e_o0 = 9000 + 100 * k; act("U hundreds to 9900", B_U);
        end
        e_cur = 1;   act("R to 1", B_R);
        for (int k = 1; k <= 5; k++) begin
            e_o0 = 9900 + 10 * k; act("U tens to 9950", B_U);
        end
        e_cur = 2;   act("L back to 2", B_L);
        e_o0 = 9999; act("U saturates at max", B_U);
        quiet("U at max holds", B_U);

        e_o0 = 0;    do_clear("clear before D");
        e_cur = 3;   act("L to 3 for D", B_L);
        for (int k = 1; k <= 9; k++) begin
            e_o0 = -1000 * k; act("D thousands", B_D);
        end
        e_o0 = -9999; act("D saturates at min", B_D);
        quiet("D at min holds", B_D);

        e_cur = 0;   act("L wraps 3 to 0", B_L);
        e_cur = 3;   act("R wraps 0 to 3", B_R);

        e_sel = 1; e_cur = 0; act("C next operand", B_C);
        e_o1 = 1;    act("U on op1", B_U);
        e_sel = 0; e_done = 1'b1; act("C on last sets done", B_C);
        e_done = 1'b0; probe("done single cycle");

        e_cur = 1;   act("U+L same tick only L", B_U | B_L);

        en = 1'b0;
        cycles(3);
        quiet("en low ignores U", B_U);
        en = 1'b1;
        cycles(3);

        // Align so the 2-cycle glitch falls entirely between debounce samples.
        do cycles(1); while (cyc % 4 != 2);
        btn = B_U;
        cycles(2);
        btn = '0;
        cycles(16);
        probe("glitch ignored");

        e_o0 = -9989; act("U tens after glitch", B_U);

        for (int i = 0; i < 200 && q.size() != 0; i++) cycles(1);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) cycles(1);
        if (!end_ack) begin
            errors++;
            checks++;
            $display("FAIL monitor drain: got no acknowledge, required acknowledge");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
